// File: rtl/io_bus_arbiter_pkg.sv
// Shared types for the non-cached I/O bus arbiter: request/response packets,
// FSM state encoding and the requester-count limit.
`ifndef NUM_CORES
`define NUM_CORES 4
`endif

package io_bus_arbiter_pkg;
    localparam int IO_ARB_MAX_REQUESTERS = 16;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef logic [3:0] core_id_t;
    typedef logic [1:0] thread_idx_t;

    typedef struct packed {
        logic              store;
        thread_idx_t       thread_idx;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] value;
    } ioreq_packet_t;

    typedef struct packed {
        core_id_t          core;
        thread_idx_t       thread_idx;
        logic [DATA_W-1:0] read_value;
    } iorsp_packet_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        READ_WAIT = 2'd2,
        RESPOND   = 2'd3
    } io_arb_state_t;
endpackage

// File: rtl/io_bus_interface.sv
// Single-beat peripheral register bus; the arbiter is the only master.
interface io_bus_interface;
    logic [io_bus_arbiter_pkg::ADDR_W-1:0] address;
    logic                                  write_en;
    logic [io_bus_arbiter_pkg::DATA_W-1:0] write_data;
    logic                                  read_en;
    logic [io_bus_arbiter_pkg::DATA_W-1:0] read_data;

    modport master (output address, write_en, write_data, read_en, input read_data);
    modport slave  (input address, write_en, write_data, read_en, output read_data);
endinterface

// File: rtl/io_bus_arbiter_rr_select.sv
// Combinational round-robin pick: first valid index at or above rr_ptr, wrapping.
module io_arbiter_rr_select #(
    parameter int NUM_REQUESTERS = 4,
    parameter int IDX_W          = 2
) (
    input  logic [NUM_REQUESTERS-1:0] valid,
    input  logic [IDX_W-1:0]          rr_ptr,
    output logic [NUM_REQUESTERS-1:0] grant_oh,
    output logic [IDX_W-1:0]          grant_idx
);
    logic found;
    int   pos;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            pos = int'(rr_ptr) + i;
            if (pos >= NUM_REQUESTERS) pos = pos - NUM_REQUESTERS;
            if (!found && valid[pos]) begin
                found         = 1'b1;
                grant_oh[pos] = 1'b1;
                grant_idx     = IDX_W'(pos);
            end
        end
    end
endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the I/O bus between cores, one access in flight.
// Optional performance pulses are built only when IO_ARB_PERF_EN is defined.
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = `NUM_CORES
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQUESTERS-1:0] ioreq_valid,
    input  ioreq_packet_t             ioreq [NUM_REQUESTERS],
    output logic [NUM_REQUESTERS-1:0] ioreq_ready,
    output logic                      iorsp_valid,
    output iorsp_packet_t             iorsp,
    io_bus_interface.master           io_bus,
    output logic                      perf_io_conflict,
    output logic                      perf_io_read,
    output logic                      perf_io_write
);
    localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    if (NUM_REQUESTERS < 1 || NUM_REQUESTERS > IO_ARB_MAX_REQUESTERS) begin : g_param_check
        $error("io_bus_arbiter: NUM_REQUESTERS out of range 1..%0d", IO_ARB_MAX_REQUESTERS);
    end

    io_arb_state_t             state, state_next;
    logic [IDX_W-1:0]          rr_ptr, winner_idx, winner_p1;
    logic [NUM_REQUESTERS-1:0] winner_oh;
    logic                      grant, store_p1;
    thread_idx_t               thread_p1;
    ioreq_packet_t             winner_req;

    io_arbiter_rr_select #(.NUM_REQUESTERS(NUM_REQUESTERS), .IDX_W(IDX_W)) u_select (
        .valid     (ioreq_valid),
        .rr_ptr    (rr_ptr),
        .grant_oh  (winner_oh),
        .grant_idx (winner_idx)
    );

    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
        if (int'(idx) >= NUM_REQUESTERS - 1) return '0;
        return idx + 1'b1;
    endfunction

    assign winner_req  = ioreq[winner_idx];
    // Gated by reset_n so no grant pulse is seen while the arbiter is held in reset.
    assign grant       = reset_n && (state == IDLE) && (|ioreq_valid);
    assign ioreq_ready = grant ? winner_oh : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (|ioreq_valid) state_next = ISSUE;
            ISSUE:     state_next = store_p1 ? RESPOND : READ_WAIT;
            READ_WAIT: state_next = RESPOND;
            RESPOND:   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // grant -> p1: winner identity kept for the response tag
    always_ff @(posedge clk) begin
        if (grant) begin
            winner_p1 <= winner_idx;
            store_p1  <= winner_req.store;
            thread_p1 <= winner_req.thread_idx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr            <= '0;
            io_bus.address    <= '0;
            io_bus.write_data <= '0;
            io_bus.write_en   <= 1'b0;
            io_bus.read_en    <= 1'b0;
            iorsp_valid       <= 1'b0;
            iorsp             <= '0;
        end else begin
            io_bus.write_en <= 1'b0;
            io_bus.read_en  <= 1'b0;
            iorsp_valid     <= 1'b0;
            case (state)
                IDLE: if (grant) begin
                    rr_ptr            <= ptr_after(winner_idx);
                    io_bus.address    <= winner_req.address;
                    io_bus.write_data <= winner_req.value;
                    io_bus.write_en   <= winner_req.store;
                    io_bus.read_en    <= !winner_req.store;
                end
                ISSUE: if (store_p1) begin
                    iorsp_valid <= 1'b1;
                    iorsp       <= '{core: core_id_t'(winner_p1), thread_idx: thread_p1,
                                     read_value: '0};
                end
                READ_WAIT: begin
                    iorsp_valid <= 1'b1;
                    iorsp       <= '{core: core_id_t'(winner_p1), thread_idx: thread_p1,
                                     read_value: io_bus.read_data};
                end
                default: ;
            endcase
        end
    end

`ifdef IO_ARB_PERF_EN
    logic [NUM_REQUESTERS-1:0] other_oh;
    logic [IDX_W-1:0]          other_idx;

    // A second pick over the losers finds whether anyone else was waiting.
    io_arbiter_rr_select #(.NUM_REQUESTERS(NUM_REQUESTERS), .IDX_W(IDX_W)) u_conflict (
        .valid     (ioreq_valid & ~winner_oh),
        .rr_ptr    (rr_ptr),
        .grant_oh  (other_oh),
        .grant_idx (other_idx)
    );

    assign perf_io_conflict = grant && other_oh[other_idx];
    assign perf_io_read     = io_bus.read_en;
    assign perf_io_write    = io_bus.write_en;
`else
    assign perf_io_conflict = 1'b0;
    assign perf_io_read     = 1'b0;
    assign perf_io_write    = 1'b0;
`endif
endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Shares the single non-cached I/O bus (`io_bus_interface`, master side) between `NUM_REQUESTERS` cores.
- Each core presents an `ioreq_packet_t`.
- The arbiter grants one request at a time in round-robin order and drives exactly one bus access for it.
- It then returns an `iorsp_packet_t` tagged with the requester's core ID and thread index.
- It sits at the top level between the cores' I/O request queues and the peripheral register fabric.

## Interface
Parameters:
- `NUM_REQUESTERS`, default `` `NUM_CORES ``: number of requesting cores, 1..16 (limited by `core_id_t` width).

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `ioreq_valid`  in  `[NUM_REQUESTERS]`  per-core request pending.
- `ioreq`  in  `ioreq_packet_t[NUM_REQUESTERS]`  per-core request; must stay stable while valid and not granted.
- `ioreq_ready`  out  `[NUM_REQUESTERS]`  one-hot grant pulse; the request is consumed in that cycle.
- `iorsp_valid`  out  1  response pulse, broadcast to all cores, no backpressure.
- `iorsp`  out  `iorsp_packet_t`  response: `core`, `thread_idx`, `read_value`.
- `io_bus`  `io_bus_interface.master`  shared peripheral bus.
- `perf_io_conflict`, `perf_io_read`, `perf_io_write`  out  1 each  performance event pulses (see Configuration).

## Operation
- FSM states: `IDLE`, `ISSUE`, `READ_WAIT`, `RESPOND`.
- `IDLE`:
  - If any `ioreq_valid` is set, pick the winner: the first valid index at or above `rr_ptr`, wrapping modulo `NUM_REQUESTERS`.
  - Pulse `ioreq_ready[winner]`, latch the packet and the winner index, set `rr_ptr <= (winner+1) mod NUM_REQUESTERS`, go to `ISSUE`.
  - If no request is valid, stay in `IDLE` with `rr_ptr` unchanged.
- `ISSUE`:
  - Drive `address` and `write_data` from the latched packet for one cycle.
  - Store: `write_en=1`, go to `RESPOND` with `read_value=0`.
  - Load: `read_en=1`, go to `READ_WAIT`.
- `READ_WAIT`: capture `io_bus.read_data` into the response register, go to `RESPOND`.
- `RESPOND`: `iorsp_valid=1` for exactly one cycle; `iorsp.core` = winner index zero-extended to 4 bits; `iorsp.thread_idx` = latched `thread_idx`; go to `IDLE`.
- `write_en` and `read_en` are never asserted together and never asserted outside `ISSUE`.
- `address` and `write_data` hold their last value when not in `ISSUE`.
- No new grant is issued until `RESPOND` completes: at most one transaction is outstanding.
- Fairness: a core that holds `ioreq_valid` is granted within `NUM_REQUESTERS` arbitration rounds.
- `NUM_REQUESTERS=1`: `rr_ptr` is a constant 0 and the winner is always 0.

## Timing
- All outputs reset to 0: `ioreq_ready`, `iorsp_valid`, `iorsp`, `write_en`, `read_en`, `address`, `write_data`, perf pulses. State resets to `IDLE` and `rr_ptr` to 0.
- Store: grant in cycle N, `write_en` in N+1, `iorsp_valid` in N+2. Next grant no earlier than N+3.
- Load: grant in N, `read_en` in N+1, `read_data` sampled at the end of N+2, `iorsp_valid` in N+3. Next grant no earlier than N+4.
- `ioreq_ready` is combinational from state, `ioreq_valid` and `rr_ptr`. All other outputs are registered.
- Reset asserted mid-transaction:
  - The in-flight access is abandoned and no response is issued.
  - Bus enables drop asynchronously.
  - Requesters re-present their requests after reset.
- A request that drops `ioreq_valid` before its grant is ignored. Withdrawal is legal only for software reset flows.

## Configuration
- `IO_ARB_PERF_EN` defined:
  - `perf_io_conflict` pulses in the grant cycle when more than one `ioreq_valid` bit is set.
  - `perf_io_read` and `perf_io_write` pulse in the `ISSUE` cycle according to the access type.
- `IO_ARB_PERF_EN` undefined: the three ports remain in the interface, tied to 0, with no associated logic.

## Structure
- Shared package (`defines`):
  - `io_arb_state_t`, a 2-bit enum of the four states.
  - `IO_ARB_MAX_REQUESTERS = 16`, checked against `NUM_REQUESTERS` by an elaboration-time assertion.
- Sub-module `io_arbiter_rr_select`: combinational round-robin winner select from the valid vector and `rr_ptr`. Outputs a one-hot grant and a binary index. Reused for the winner and the conflict detect.
- Top module holds the FSM, the latched request, the response register and `rr_ptr`.

## Test plan
- Single load: core 2, thread 1, address `0xFFFF0040`; bus returns `0x12345678` -> `read_en` one cycle after grant; `iorsp_valid` 3 cycles after grant with `core=2`, `thread_idx=1`, `read_value=0x12345678`.
- Single store: core 0, address `0xFFFF0000`, value `0xA5` -> `write_en` one cycle with `write_data=0xA5`; response 2 cycles after grant with `read_value=0`.
- Contention, 4 requesters all valid continuously from reset -> grant order 0,1,2,3,0,…; each grant is 3 or 4 cycles apart; `perf_io_conflict` pulses on every grant when `IO_ARB_PERF_EN` is defined, stays 0 otherwise.
- Wrap-around: `rr_ptr=3` and only core 1 valid -> core 1 granted; `rr_ptr` becomes 2.
- Reset asserted during `READ_WAIT` -> `read_en` and `iorsp_valid` are 0 immediately; after release, no response appears until a new request.
- Idle: no valid requests for 100 cycles -> no grants, no bus enables, `rr_ptr` unchanged.
